fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL be the PC loaded on reset.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 resetn  input  1  SHALL be the synchronous, active-high reset: resetn=1 at a rising clk edge resets the block.
REQ-004 redirect_valid  input  1  SHALL indicate a branch/jump redirect request.
REQ-005 redirect_pc  input  32  SHALL carry the new fetch PC; bits [1:0] are ignored and forced to 0.
REQ-006 imem_req  output  1  SHALL be the instruction-memory request valid.
REQ-007 imem_addr  output  32  SHALL be the request address, equal to the current PC.
REQ-008 imem_ready  input  1  SHALL be the memory's acceptance of imem_req in the same cycle.
REQ-009 imem_rvalid / imem_rdata  input  1/32  SHALL return one 32-bit instruction per accepted request, at least 1 cycle after acceptance.
REQ-010 full_ifq  input  1  SHALL be the fetch-queue full flag.
REQ-011 enq_ifq / data_in_ifq  output  1/32  SHALL push one instruction into the fetch queue.

Function
REQ-012 The FSM SHALL have states REQ, WAIT, HOLD, DRAIN, with at most one memory request outstanding.
REQ-013 imem_req SHALL be combinational: 1 iff state==REQ and redirect_valid==0; imem_addr=pc in all states.
REQ-014 REQ: when imem_req and imem_ready, pc<=pc+4 (32-bit wrap, 32'hFFFF_FFFC -> 0) and state<=WAIT; otherwise remain in REQ.
REQ-015 WAIT, imem_rvalid, full_ifq=0: enq_ifq<=1, data_in_ifq<=imem_rdata, state<=REQ.
REQ-016 WAIT, imem_rvalid, full_ifq=1: hold_buf<=imem_rdata, state<=HOLD; no enqueue.
REQ-017 HOLD: when full_ifq=0, enq_ifq<=1, data_in_ifq<=hold_buf, state<=REQ; else remain.
REQ-018 enq_ifq SHALL be registered and high for exactly one cycle per instruction; data_in_ifq holds its value until the next enqueue.
REQ-019 Enqueues SHALL be separated by at least two cycles, so full_ifq is always current when sampled.
REQ-020 Redirect in REQ or HOLD: pc<={redirect_pc[31:2],2'b00}, hold_buf discarded, state<=REQ, enq_ifq<=0.
REQ-021 Redirect in WAIT without imem_rvalid: pc<=redirect target, state<=DRAIN; DRAIN discards the next imem_rvalid and then goes to REQ.
REQ-022 Redirect in WAIT with imem_rvalid in the same cycle: the response is discarded, pc<=target, state<=REQ, enq_ifq<=0.
REQ-023 Redirect in DRAIN: pc<=target; the pending response is still discarded.
REQ-024 Instruction order in the queue SHALL equal program (PC) order; no instruction from a squashed path is ever enqueued.

Reset
REQ-025 On reset: state=REQ, pc=RESET_PC, enq_ifq=0, data_in_ifq=0, hold_buf=0; any outstanding response arriving afterwards SHALL be ignored (state DRAIN if a request was outstanding at reset).
REQ-026 Reset SHALL take priority over redirect and memory responses in the same cycle.

Configuration
REQ-027 With macro FETCH_PERF_CNT_EN defined, the block SHALL add outputs fetch_cnt[31:0] (incremented per enq_ifq) and stall_cnt[31:0] (incremented per cycle in HOLD), both reset to 0 and wrapping modulo 2^32.
REQ-028 Without FETCH_PERF_CNT_EN, those ports and counters SHALL not exist; all other behaviour is identical.

Verification
REQ-029 Reset with RESET_PC=32'h100, memory always ready, 1-cycle response latency -> imem_addr sequence 100,104,108; enq_ifq pulses every 2 cycles with matching rdata.
REQ-030 full_ifq=1 when the response to 32'h104 arrives, released 5 cycles later -> state HOLD for 5 cycles, no imem_req, then a single enqueue of the 104 instruction; stall_cnt=5 if enabled.
REQ-031 Redirect to 32'h2002 while WAIT for 0x108 -> the 0x108 response is dropped, next imem_addr=32'h2000, no 0x108 enqueue.
REQ-032 Redirect in the same cycle as imem_rvalid -> no enqueue that cycle; next request goes to the redirect target.
REQ-033 pc=32'hFFFF_FFFC accepted -> next imem_addr=32'h0000_0000.
REQ-034 Reset asserted during WAIT, stale rvalid arrives 2 cycles later -> no enqueue; first fetch is from RESET_PC.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch sequencer: one outstanding imem request, single-entry hold buffer, redirect squash.
// Optional perf counters (fetch_cnt, stall_cnt) are compiled in with FETCH_PERF_CNT_EN.
//
// state  | meaning
// -------+-----------------------------------------------------------
// REQ    | presenting pc to imem, waiting for imem_ready
// WAIT   | request accepted, waiting for imem_rvalid
// HOLD   | response captured in hold buffer, waiting for queue space
// DRAIN  | squashed request still in flight, discard its response
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   input  logic        full_ifq,
   output logic        enq_ifq,
   output logic [31:0] data_in_ifq
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0] fetch_cnt,
   output logic [31:0] stall_cnt
`endif
);

   typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_DRAIN} state_t;

   state_t      r_state, w_state_nxt;
   logic [31:0] r_pc, w_pc_nxt;
   logic [31:0] r_hold_buf, w_hold_nxt;
   logic        r_enq, w_enq_nxt;
   logic [31:0] r_data, w_data_nxt;
   logic [31:0] w_redir_pc;
   logic        w_outstanding;

   assign w_redir_pc  = redirect_pc & ~32'h0000_0003;
   assign imem_req    = (r_state == S_REQ) && !redirect_valid;
   assign imem_addr   = r_pc;
   assign enq_ifq     = r_enq;
   assign data_in_ifq = r_data;

   // A response still owed by memory at reset must be swallowed afterwards.
   assign w_outstanding = ((r_state == S_WAIT) || (r_state == S_DRAIN)) && !imem_rvalid;

   always_comb begin
      w_state_nxt = r_state;
      w_pc_nxt    = r_pc;
      w_hold_nxt  = r_hold_buf;
      w_enq_nxt   = 1'b0;
      w_data_nxt  = r_data;
      case (r_state)
         S_REQ: begin
            if (redirect_valid) begin
               w_pc_nxt = w_redir_pc;
            end else if (imem_ready) begin
               w_pc_nxt    = r_pc + 32'd4;
               w_state_nxt = S_WAIT;
            end
         end
         S_WAIT: begin
            if (redirect_valid) begin
               w_pc_nxt    = w_redir_pc;
               w_state_nxt = imem_rvalid ? S_REQ : S_DRAIN;
            end else if (imem_rvalid) begin
               if (full_ifq) begin
                  w_hold_nxt  = imem_rdata;
                  w_state_nxt = S_HOLD;
               end else begin
                  w_enq_nxt   = 1'b1;
                  w_data_nxt  = imem_rdata;
                  w_state_nxt = S_REQ;
               end
            end
         end
         S_HOLD: begin
            if (redirect_valid) begin
               w_pc_nxt    = w_redir_pc;
               w_hold_nxt  = 32'd0;
               w_state_nxt = S_REQ;
            end else if (!full_ifq) begin
               w_enq_nxt   = 1'b1;
               w_data_nxt  = r_hold_buf;
               w_state_nxt = S_REQ;
            end
         end
         S_DRAIN: begin
            if (redirect_valid) w_pc_nxt = w_redir_pc;
            if (imem_rvalid)    w_state_nxt = S_REQ;
         end
         default: w_state_nxt = S_REQ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (resetn) begin
         r_state    <= w_outstanding ? S_DRAIN : S_REQ;
         r_pc       <= RESET_PC;
         r_hold_buf <= 32'd0;
         r_enq      <= 1'b0;
         r_data     <= 32'd0;
      end else begin
         r_state    <= w_state_nxt;
         r_pc       <= w_pc_nxt;
         r_hold_buf <= w_hold_nxt;
         r_enq      <= w_enq_nxt;
         r_data     <= w_data_nxt;
      end
   end

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] r_fetch_cnt;
   logic [31:0] r_stall_cnt;

   always_ff @(posedge clk) begin
      if (resetn) begin
         r_fetch_cnt <= 32'd0;
         r_stall_cnt <= 32'd0;
      end else begin
         if (r_enq)              r_fetch_cnt <= r_fetch_cnt + 32'd1;
         if (r_state == S_HOLD)  r_stall_cnt <= r_stall_cnt + 32'd1;
      end
   end

   assign fetch_cnt = r_fetch_cnt;
   assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: directed phases push expected request addresses and
// enqueued instruction addresses; a negedge monitor pops and compares.
module tb_fetch_unit;
   localparam logic [31:0] RST_PC = 32'h0000_0100;

   logic        clk;
   logic        resetn;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        full_ifq;
   logic        enq_ifq;
   logic [31:0] data_in_ifq;

   fetch_unit #(.RESET_PC(RST_PC)) dut (
      .clk(clk), .resetn(resetn),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
      .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
      .full_ifq(full_ifq), .enq_ifq(enq_ifq), .data_in_ifq(data_in_ifq)
   );

   int          n_checks = 0;
   int          n_bad    = 0;
   int          cyc      = 0;
   int          base     = 0;
   int          last_enq_cyc = -1;
   int          mem_lat  = 1;
   logic        pend     = 1'b0;
   int          pend_cnt = 0;
   logic [31:0] pend_addr = 32'd0;
   logic [31:0] exp_addr[$];
   logic [31:0] exp_data[$];

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] instr(input logic [31:0] a);
      return ~a ^ 32'h5A5A_A5A5;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   // memory model: one response per accepted request, mem_lat cycles later
   initial begin
      imem_rvalid = 1'b0;
      imem_rdata  = 32'd0;
      forever begin
         @(negedge clk);
         imem_rvalid = 1'b0;
         if (pend) begin
            if (pend_cnt == 0) begin
               imem_rvalid = 1'b1;
               imem_rdata  = instr(pend_addr);
               pend = 1'b0;
            end else begin
               pend_cnt--;
            end
         end
         if (imem_req && imem_ready) begin
            chk("one_outstanding", {31'd0, pend}, 32'd0);
            pend      = 1'b1;
            pend_addr = imem_addr;
            pend_cnt  = mem_lat - 1;
         end
      end
   end

   // monitor
   initial begin
      logic [31:0] e;
      forever begin
         @(negedge clk);
         if (imem_req && imem_ready) begin
            if (exp_addr.size() == 0) chk("extra_req", imem_addr, 32'hXXXX_XXXX);
            else begin
               e = exp_addr.pop_front();
               chk("req_addr", imem_addr, e);
            end
         end
         if (enq_ifq) begin
            last_enq_cyc = cyc;
            if (exp_data.size() == 0) chk("extra_enq", data_in_ifq, 32'hXXXX_XXXX);
            else begin
               e = exp_data.pop_front();
               chk("enq_data", data_in_ifq, instr(e));
            end
         end
      end
   end

   task automatic cyc_to(input int n);
      while (cyc != base + n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      resetn = 1'b1; imem_ready = 1'b0; redirect_valid = 1'b0; full_ifq = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("rst_addr", imem_addr, RST_PC);
      chk("rst_enq",  {31'd0, enq_ifq}, 32'd0);
      chk("rst_data", data_in_ifq, 32'd0);
      chk("rst_req",  {31'd0, imem_req}, 32'd1);
      @(posedge clk); #1;
      resetn = 1'b0;
      base = cyc;
   endtask

   task automatic finish_phase(input string nm);
      int t = 0;
      while ((exp_addr.size() != 0 || exp_data.size() != 0 || pend) && t < 30) begin
         @(posedge clk); #1; t++;
      end
      chk({nm, "_addr_left"}, 32'(exp_addr.size()), 32'd0);
      chk({nm, "_data_left"}, 32'(exp_data.size()), 32'd0);
   endtask

   initial begin
      resetn = 1'b1; imem_ready = 1'b0; redirect_valid = 1'b0;
      redirect_pc = 32'd0; full_ifq = 1'b0;

      // A: streaming, 1-cycle latency, enqueue every 2 cycles
      mem_lat = 1;
      do_reset();
      exp_addr = '{32'h100, 32'h104, 32'h108};
      exp_data = '{32'h100, 32'h104, 32'h108};
      imem_ready = 1'b1;
      cyc_to(3); chk("A_enq0_cyc", 32'(last_enq_cyc - base), 32'd2);
      cyc_to(5); chk("A_enq1_cyc", 32'(last_enq_cyc - base), 32'd4);
      cyc_to(6); imem_ready = 1'b0;
      cyc_to(7); chk("A_enq2_cyc", 32'(last_enq_cyc - base), 32'd6);
      finish_phase("A");

      // B: queue full when 0x104 returns, released after 5 HOLD cycles
      do_reset();
      exp_addr = '{32'h100, 32'h104, 32'h108};
      exp_data = '{32'h100, 32'h104, 32'h108};
      imem_ready = 1'b1;
      cyc_to(3); full_ifq = 1'b1;
      cyc_to(4);
      repeat (4) begin
         @(negedge clk); chk("B_hold_noreq", {31'd0, imem_req}, 32'd0);
      end
      cyc_to(8); full_ifq = 1'b0;
      @(negedge clk); chk("B_hold_noreq", {31'd0, imem_req}, 32'd0);
      cyc_to(10); imem_ready = 1'b0;
      chk("B_hold_enq_cyc", 32'(last_enq_cyc - base), 32'd9);
      finish_phase("B");

      // C: redirect in WAIT without response, 2-cycle latency -> DRAIN
      mem_lat = 2;
      do_reset();
      exp_addr = '{32'h100, 32'h104, 32'h108, 32'h2000};
      exp_data = '{32'h100, 32'h104, 32'h2000};
      imem_ready = 1'b1;
      cyc_to(7); redirect_valid = 1'b1; redirect_pc = 32'h2002;
      cyc_to(8); redirect_valid = 1'b0;
      cyc_to(10); imem_ready = 1'b0;
      finish_phase("C");

      // D: redirect coincident with rvalid, then redirect in REQ
      mem_lat = 1;
      do_reset();
      exp_addr = '{32'h100, 32'h104, 32'h3000, 32'h4000};
      exp_data = '{32'h100, 32'h3000, 32'h4000};
      imem_ready = 1'b1;
      cyc_to(3); redirect_valid = 1'b1; redirect_pc = 32'h3003;
      cyc_to(4); redirect_valid = 1'b0;
      cyc_to(6); redirect_valid = 1'b1; redirect_pc = 32'h4000;
      @(negedge clk); chk("D_redir_noreq", {31'd0, imem_req}, 32'd0);
      cyc_to(7); redirect_valid = 1'b0;
      cyc_to(8); imem_ready = 1'b0;
      finish_phase("D");

      // E: pc wrap from 0xFFFF_FFFC
      do_reset();
      exp_addr = '{32'hFFFF_FFFC, 32'h0};
      exp_data = '{32'hFFFF_FFFC, 32'h0};
      redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFF;
      @(negedge clk); chk("E_redir_noreq", {31'd0, imem_req}, 32'd0);
      cyc_to(1); redirect_valid = 1'b0; imem_ready = 1'b1;
      @(negedge clk); chk("E_target_addr", imem_addr, 32'hFFFF_FFFC);
      cyc_to(4); imem_ready = 1'b0;
      finish_phase("E");

      // F: reset while WAIT, stale response arrives afterwards and is dropped
      mem_lat = 3;
      do_reset();
      exp_addr = '{32'h100, 32'h100};
      exp_data = '{32'h100};
      imem_ready = 1'b1;
      cyc_to(1); imem_ready = 1'b0; resetn = 1'b1;
      cyc_to(2); resetn = 1'b0; imem_ready = 1'b1;
      @(negedge clk);
      chk("F_drain_addr",  imem_addr, RST_PC);
      chk("F_drain_noreq", {31'd0, imem_req}, 32'd0);
      cyc_to(3);
      @(negedge clk); chk("F_drain_noreq", {31'd0, imem_req}, 32'd0);
      cyc_to(5); imem_ready = 1'b0;
      finish_phase("F");

      $display("test done: total=%0d bad=%0d", n_checks, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end
endmodule
